// File: rtl/reg_view_ctrl.sv
// Purpose : step a register-file read address with two raw pushbuttons and latch read data into a stable display word.
// Latency : press -> step pulse is 2 sync + DEB_CNT + 1 cycles; step -> seg load is RD_LAT + 1 cycles.
// Backpr. : none; pulses arriving while a step is in progress (busy=1) are dropped, never queued.
//
// Ports:
//   clk      board clock, rising edge
//   reset    asynchronous active-low reset
//   btn_up   raw pushbutton, asynchronous, press = 1; steps address +1 (wraps)
//   btn_dn   raw pushbutton, asynchronous, press = 1; steps address -1 (wraps)
//   freeze   1 = hold seg while idle (a step still reloads it)
//   rd_data  register-file read data for rd_addr, valid RD_LAT cycles after rd_addr changes
//   rd_addr  register-file read address
//   seg      display word
//   busy     1 while a step is in progress (WAIT/LATCH)
//
// Build option: define SHOW_ADDR_EN to place the address in the top byte of every seg load
// ({zero-padded rd_addr, rd_data[23:0]}); requires ADDR_W <= 8.

module reg_view_ctrl #(
   parameter int ADDR_W  = 5,
   parameter int DEB_CNT = 1000000,
   parameter int RD_LAT  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_up,
   input  logic              btn_dn,
   input  logic              freeze,
   input  logic [31:0]       rd_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       seg,
   output logic              busy
);

   localparam int CNT_W  = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CNT - 1);
   localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_LATCH = 2'd2
   } state_t;

   // bit 0 = up button, bit 1 = down button
   logic [1:0] btn_raw;
   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] deb_lvl;
   logic [1:0] pulse;
   logic       up_p;
   logic       dn_p;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [WCNT_W-1:0]   wcnt;
   logic [WCNT_W-1:0]   wcnt_nxt;
   logic [31:0]         seg_nxt;
   logic [31:0]         seg_word;

   assign btn_raw = {btn_dn, btn_up};

   // Two-flop synchronisers for the asynchronous buttons.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Debounce: the synced level must disagree with the accepted level for
   // DEB_CNT consecutive cycles before it is accepted. Any agreeing cycle
   // restarts the count, so bounce shorter than DEB_CNT never gets through.
   // A one-cycle pulse is registered only on an accepted 0->1 change.
   for (genvar i = 0; i < 2; i++) begin : g_deb
      logic [CNT_W-1:0] cnt;
      logic             lvl;
      logic             p;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt <= '0;
            lvl <= 1'b0;
            p   <= 1'b0;
         end else begin
            p <= 1'b0;
            if (sync2[i] == lvl) begin
               cnt <= '0;
            end else if (cnt == DEB_LAST) begin
               cnt <= '0;
               lvl <= sync2[i];
               p   <= sync2[i];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      assign deb_lvl[i] = lvl;
      assign pulse[i]   = p;
   end

   assign up_p = pulse[0];
   assign dn_p = pulse[1];

   // Word written into seg on every load.
`ifdef SHOW_ADDR_EN
   assign seg_word = {8'(rd_addr), rd_data[23:0]};
`else
   assign seg_word = rd_data;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         rd_addr <= '0;
         wcnt    <= '0;
         seg     <= '0;
      end else begin
         state   <= state_nxt;
         rd_addr <= addr_nxt;
         wcnt    <= wcnt_nxt;
         seg     <= seg_nxt;
      end
   end

   // Next-state and outputs. The address moves on entry to WAIT, so the
   // read data sampled in LATCH always belongs to the post-step address;
   // the idle live refresh is suppressed on the step cycle for the same reason.
   always_comb begin
      state_nxt = state;
      addr_nxt  = rd_addr;
      wcnt_nxt  = wcnt;
      seg_nxt   = seg;
      busy      = 1'b0;
      case (state)
         S_IDLE: begin
            if (up_p ^ dn_p) begin
               addr_nxt  = up_p ? rd_addr + 1'b1 : rd_addr - 1'b1;
               wcnt_nxt  = WAIT_LOAD;
               state_nxt = S_WAIT;
            end else if (!freeze) begin
               // Simultaneous up/down pulses cancel and count as no step.
               seg_nxt = seg_word;
            end
         end
         S_WAIT: begin
            busy = 1'b1;
            if (wcnt == '0) begin
               state_nxt = S_LATCH;
            end else begin
               wcnt_nxt = wcnt - 1'b1;
            end
         end
         S_LATCH: begin
            busy      = 1'b1;
            seg_nxt   = seg_word;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_view_ctrl.sv
// Bench for reg_view_ctrl with DEB_CNT=4, RD_LAT=2 and a 2-cycle register-file model.
module tb_reg_view_ctrl;

   localparam int AW    = 5;
   localparam int NADDR = 32;

   logic          clk;
   logic          reset;
   logic          btn_up;
   logic          btn_dn;
   logic          freeze;
   logic [31:0]   rd_data;
   logic [AW-1:0] rd_addr;
   logic [31:0]   seg;
   logic          busy;

   logic [31:0]   mem [NADDR];
   logic [31:0]   p1;

   int passed;
   int failed;
   int total;
   int exp_addr;
   int busy_cycles;

   reg_view_ctrl #(
      .ADDR_W (AW),
      .DEB_CNT(4),
      .RD_LAT (2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .btn_up (btn_up),
      .btn_dn (btn_dn),
      .freeze (freeze),
      .rd_data(rd_data),
      .rd_addr(rd_addr),
      .seg    (seg),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: data for an address appears two clocks after the address.
   always @(posedge clk) begin
      p1      <= mem[rd_addr];
      rd_data <= p1;
   end

   // Expected display word for an address, from the model memory.
   function automatic logic [31:0] exp_seg(input int a);
`ifdef SHOW_ADDR_EN
      logic [31:0] w;
      w = mem[a];
      return {8'(a), w[23:0]};
`else
      return mem[a];
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Advance to the next falling edge and record whether busy was high.
   task automatic tick();
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
   endtask

   // Drive one press (up and/or down, dn optionally delayed by 'stagger'),
   // then release and let the debouncers settle.
   task automatic press(input bit up, input bit dn, input int hold, input int stagger);
      busy_cycles = 0;
      for (int i = 0; i < hold + stagger; i++) begin
         btn_up = up && (i < hold);
         btn_dn = dn && (i >= stagger) && (i < stagger + hold);
         tick();
      end
      btn_up = 1'b0;
      btn_dn = 1'b0;
      repeat (14) tick();
   endtask

   task automatic check_state(input string tag, input int exp_busy);
      check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
      check({tag, "_addr"}, 32'(rd_addr), 32'(exp_addr));
      check({tag, "_seg"}, seg, exp_seg(exp_addr));
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [31:0] old_seg;
      bit          found;
      bit          u;
      int          h;

      passed = 0;
      failed = 0;
      total  = 0;
      busy_cycles = 0;
      exp_addr = 0;
      for (int i = 0; i < NADDR; i++) mem[i] = 32'hA000_0000 + 32'(i);
      btn_up = 1'b0;
      btn_dn = 1'b0;
      freeze = 1'b0;
      reset  = 1'b1;
      #1 reset = 1'b0;

      // Reset values
      repeat (3) tick();
      check("rst_addr", 32'(rd_addr), 32'd0);
      check("rst_seg", seg, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      repeat (4) tick();
      check("live_after_reset", seg, exp_seg(0));

      // First step up: three busy cycles, address 1
      press(1'b1, 1'b0, 10, 0);
      exp_addr = 1;
      check_state("first_up", 3);

      // Bounce shorter than the debounce window
      busy_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         btn_up = ((i / 2) % 2) == 0;
         tick();
      end
      btn_up = 1'b0;
      repeat (14) tick();
      check_state("bounce", 0);

      // Down to 0, then down wraps to 31
      press(1'b0, 1'b1, 9, 0);
      exp_addr = 0;
      check_state("dn_to_0", 3);
      press(1'b0, 1'b1, 9, 0);
      exp_addr = NADDR - 1;
      check_state("dn_wrap", 3);

      // 32 steps up: full wrap back to 31
      for (int i = 0; i < NADDR; i++) begin
         press(1'b1, 1'b0, 8, 0);
         exp_addr = (exp_addr + 1) % NADDR;
         check_state("up_lap", 3);
      end

      // Simultaneous identical presses cancel
      press(1'b1, 1'b1, 10, 0);
      check_state("simul", 0);

      // Second pulse arriving while busy is dropped
      for (int s = 1; s <= 3; s++) begin
         press(1'b1, 1'b1, 9, s);
         exp_addr = (exp_addr + 1) % NADDR;
         check_state("drop_busy", 3);
      end

      // Freeze holds seg against data changes; unfreeze follows next cycle
      freeze = 1'b1;
      tick();
      old_seg = exp_seg(exp_addr);
      mem[exp_addr] = mem[exp_addr] ^ 32'h0055_AA00;
      repeat (5) tick();
      check("freeze_hold", seg, old_seg);
      freeze = 1'b0;
      tick();
      check("unfreeze_follow", seg, exp_seg(exp_addr));

      // Freeze with a step: LATCH still loads, then hold again
      freeze = 1'b1;
      press(1'b1, 1'b0, 10, 0);
      exp_addr = (exp_addr + 1) % NADDR;
      check_state("freeze_step", 3);
      old_seg = exp_seg(exp_addr);
      mem[exp_addr] = mem[exp_addr] + 32'h0001_0101;
      repeat (5) tick();
      check("freeze_after_step", seg, old_seg);
      freeze = 1'b0;
      repeat (2) tick();
      check("unfreeze2", seg, exp_seg(exp_addr));

      // Randomized presses against the address/data model
      for (int i = 0; i < NADDR; i++) mem[i] = $urandom;
      repeat (4) tick();
      for (int n = 0; n < 16; n++) begin
         h = int'($urandom_range(8, 12));
         if ($urandom_range(0, 4) == 0) begin
            press(1'b1, 1'b1, h, 0);
            check_state("rand_simul", 0);
         end else begin
            u = bit'($urandom_range(0, 1));
            press(u, !u, h, 0);
            exp_addr = u ? (exp_addr + 1) % NADDR : (exp_addr + NADDR - 1) % NADDR;
            check_state("rand_step", 3);
         end
      end

      // Asynchronous reset in the middle of a step
      for (int i = 0; i < NADDR; i++) mem[i] = 32'hA000_0000 + 32'(i);
      btn_up = 1'b1;
      found  = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (busy === 1'b1) found = 1'b1;
      end
      check("mid_wait_seen", 32'(found), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_addr", 32'(rd_addr), 32'd0);
      check("async_rst_seg", seg, 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      btn_up = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      exp_addr = 0;
      busy_cycles = 0;
      repeat (14) tick();
      check_state("after_async_rst", 0);

      // Five steps up to address 5
      for (int i = 0; i < 5; i++) begin
         press(1'b1, 1'b0, 9, 0);
         exp_addr = exp_addr + 1;
      end
      check("addr5", 32'(rd_addr), 32'd5);
`ifdef SHOW_ADDR_EN
      check("addr5_seg", seg, 32'h0500_0005);
`else
      check("addr5_seg", seg, 32'hA000_0005);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
